// File: rtl/shift_issuer.sv
// shift_issuer: initiator side of the shifter stb/ack handshake.
// Takes decoded eBPF LSH/RSH/ARSH (ALU64 and ALU32) instructions, prepares the
// shifter operand and masked count, issues a single strobe, waits for ack and
// returns the formatted result as a one-cycle register write-back.
// Optional build macro: SHIFT_TIMEOUT_EN -- abort WAIT after timeout_cycles
// cycles without ack, pulsing err and producing no write-back.
module shift_issuer #(
    parameter int data_width     = 64,
    parameter int reg_addr_width = 4,
    parameter int timeout_cycles = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [1:0]                req_op,
    input  logic                      req_is32,
    input  logic [reg_addr_width-1:0] req_dst,
    input  logic [data_width-1:0]     req_value,
    input  logic [data_width-1:0]     req_shift,
    output logic                      sh_stb,
    output logic                      sh_arith,
    output logic                      sh_left,
    output logic [data_width-1:0]     sh_value,
    output logic [data_width-1:0]     sh_shift,
    input  logic [data_width-1:0]     sh_out,
    input  logic                      sh_ack,
    output logic                      wb_valid,
    output logic [reg_addr_width-1:0] wb_dst,
    output logic [data_width-1:0]     wb_data,
    output logic                      err
);

    localparam logic [1:0] OP_LSH  = 2'd0;
    localparam logic [1:0] OP_ARSH = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Destination and operand class travel with the instruction until write-back.
    logic [reg_addr_width-1:0] dst_q;
    logic                      is32_q;

    logic xfer;
    logic legal_xfer;
    logic illegal_xfer;
    logic timeout_hit;

    // eBPF masks the count to the operand width: 6 bits for ALU64, 5 for ALU32.
    function automatic logic [data_width-1:0] mask_shift(
        input logic [data_width-1:0] shift,
        input logic                  is32
    );
        logic [data_width-1:0] m;
        if (is32) m = data_width'(shift[4:0]);
        else      m = data_width'(shift[5:0]);
        return m;
    endfunction

    // ALU32 operands are widened so the 64-bit shifter yields the correct low
    // word: sign-extend for ARSH (sign bit feeds in), zero-extend otherwise.
    function automatic logic [data_width-1:0] prep_value(
        input logic [data_width-1:0] value,
        input logic                  is32,
        input logic [1:0]            op
    );
        logic [data_width-1:0] v;
        if (!is32)            v = value;
        else if (op == OP_ARSH) v = {{(data_width-32){value[31]}}, value[31:0]};
        else                  v = {{(data_width-32){1'b0}}, value[31:0]};
        return v;
    endfunction

    // ALU32 results always zero the upper word of the destination register.
    function automatic logic [data_width-1:0] format_result(
        input logic [data_width-1:0] res,
        input logic                  is32
    );
        logic [data_width-1:0] r;
        if (is32) r = {{(data_width-32){1'b0}}, res[31:0]};
        else      r = res;
        return r;
    endfunction

    assign req_ready    = (state_q == IDLE);
    assign xfer         = req_valid && req_ready;
    assign legal_xfer   = xfer && (req_op != OP_ILL);
    assign illegal_xfer = xfer && (req_op == OP_ILL);

`ifdef SHIFT_TIMEOUT_EN
    localparam int CNT_W = $clog2(timeout_cycles + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts cycles spent in WAIT; cleared whenever the FSM is about to enter it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt <= '0;
        end else if (state_q == WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state_q == WAIT) && !sh_ack &&
                         (wait_cnt == CNT_W'(timeout_cycles - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state logic for the issue/wait handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (legal_xfer) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (sh_ack)           state_d = DONE;
                else if (timeout_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus registered shifter, write-back and error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sh_stb   <= 1'b0;
            sh_arith <= 1'b0;
            sh_left  <= 1'b0;
            sh_value <= '0;
            sh_shift <= '0;
            wb_valid <= 1'b0;
            wb_dst   <= '0;
            wb_data  <= '0;
            err      <= 1'b0;
        end else begin
            state_q <= state_d;
            // Strobe is high only while in ISSUE; never held into WAIT since
            // the shifter would restart on a strobe seen in its ack cycle.
            sh_stb   <= (state_q == IDLE) && legal_xfer;
            wb_valid <= (state_q == WAIT) && sh_ack;
            err      <= illegal_xfer || timeout_hit;
            // Shifter inputs change only on acceptance, so they stay stable
            // through ISSUE and WAIT until the ack arrives.
            if (legal_xfer) begin
                sh_left  <= (req_op == OP_LSH);
                sh_arith <= (req_op == OP_ARSH);
                sh_shift <= mask_shift(req_shift, req_is32);
                sh_value <= prep_value(req_value, req_is32, req_op);
            end
            if ((state_q == WAIT) && sh_ack) begin
                wb_data <= format_result(sh_out, is32_q);
                wb_dst  <= dst_q;
            end
        end
    end

    // Instruction context captured on acceptance; never observed before then.
    always_ff @(posedge clk) begin
        if (legal_xfer) begin
            dst_q  <= req_dst;
            is32_q <= req_is32;
        end
    end

endmodule

// File: tb/tb_shift_issuer.sv
// tb_shift_issuer: scoreboard bench for shift_issuer with a behavioural
// shifter responder that acks two cycles after each strobe.
module tb_shift_issuer;

    localparam int DW = 64;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic          req_is32;
    logic [AW-1:0] req_dst;
    logic [DW-1:0] req_value;
    logic [DW-1:0] req_shift;
    logic          sh_stb;
    logic          sh_arith;
    logic          sh_left;
    logic [DW-1:0] sh_value;
    logic [DW-1:0] sh_shift;
    logic [DW-1:0] sh_out;
    logic          sh_ack;
    logic          wb_valid;
    logic [AW-1:0] wb_dst;
    logic [DW-1:0] wb_data;
    logic          err;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  ack_en  = 1'b1;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    shift_issuer #(
        .data_width    (DW),
        .reg_addr_width(AW),
        .timeout_cycles(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_is32 (req_is32),
        .req_dst  (req_dst),
        .req_value(req_value),
        .req_shift(req_shift),
        .sh_stb   (sh_stb),
        .sh_arith (sh_arith),
        .sh_left  (sh_left),
        .sh_value (sh_value),
        .sh_shift (sh_shift),
        .sh_out   (sh_out),
        .sh_ack   (sh_ack),
        .wb_valid (wb_valid),
        .wb_dst   (wb_dst),
        .wb_data  (wb_data),
        .err      (err)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // eBPF reference semantics computed directly from the request fields.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic is32,
                                              input logic [63:0] v, input logic [63:0] s);
        logic [31:0] r32;
        logic [63:0] r64;
        if (is32) begin
            case (op)
                2'd0:    r32 = v[31:0] << s[4:0];
                2'd1:    r32 = v[31:0] >> s[4:0];
                default: r32 = $unsigned($signed(v[31:0]) >>> s[4:0]);
            endcase
            return {32'h0, r32};
        end
        case (op)
            2'd0:    r64 = v << s[5:0];
            2'd1:    r64 = v >> s[5:0];
            default: r64 = $unsigned($signed(v) >>> s[5:0]);
        endcase
        return r64;
    endfunction

    // Behavioural 64-bit shifter: samples inputs on stb, acks two cycles later.
    // With ack_en low the ack is held back and released once ack_en rises.
    initial begin
        int pend;
        bit held;
        pend   = 0;
        held   = 1'b0;
        sh_ack = 1'b0;
        sh_out = '0;
        forever begin
            @(negedge clk);
            sh_ack = 1'b0;
            if (held && ack_en) begin
                sh_ack = 1'b1;
                held   = 1'b0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (ack_en) sh_ack = 1'b1;
                    else        held   = 1'b1;
                end
            end
            if (sh_stb) begin
                pend = 2;
                if (sh_left)       sh_out = sh_value << sh_shift[5:0];
                else if (sh_arith) sh_out = $unsigned($signed(sh_value) >>> sh_shift[5:0]);
                else               sh_out = sh_value >> sh_shift[5:0];
            end
        end
    end

    task automatic drive_req(input logic [1:0] op, input logic is32, input logic [AW-1:0] dst,
                             input logic [63:0] v, input logic [63:0] s);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_is32  = is32;
        req_dst   = dst;
        req_value = v;
        req_shift = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic is32,
                          input logic [AW-1:0] dst, input logic [63:0] v,
                          input logic [63:0] s, input logic [63:0] exp_data);
        exp_t        e;
        exp_t        got;
        int          cyc;
        bit          seen;
        logic [63:0] exp_val;
        logic [63:0] exp_sh;
        e.dst  = dst;
        e.data = exp_data;
        sb.push_back(e);
        exp_sh = is32 ? {59'h0, s[4:0]} : {58'h0, s[5:0]};
        if (!is32)          exp_val = v;
        else if (op == 2'd2) exp_val = {{32{v[31]}}, v[31:0]};
        else                exp_val = {32'h0, v[31:0]};
        drive_req(op, is32, dst, v, s);
        @(negedge clk);
        chk({tag, "_stb"},   64'(sh_stb), 64'd1);
        chk({tag, "_left"},  64'(sh_left), 64'(op == 2'd0));
        chk({tag, "_arith"}, 64'(sh_arith), 64'(op == 2'd2));
        chk({tag, "_shift"}, sh_shift, exp_sh);
        chk({tag, "_value"}, sh_value, exp_val);
        chk({tag, "_ready_busy"}, 64'(req_ready), 64'd0);
        @(negedge clk);
        chk({tag, "_stb_1cyc"}, 64'(sh_stb), 64'd0);
        cyc  = 2;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (wb_valid) seen = 1'b1;
        end
        if (!seen) begin
            chk({tag, "_wb_timeout"}, 64'd0, 64'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            chk({tag, "_latency"}, 64'(cyc), 64'd4);
            if (sb.size() == 0) begin
                chk({tag, "_sb_empty"}, 64'd0, 64'd1);
            end else begin
                got = sb.pop_front();
                chk({tag, "_wb_dst"},  64'(wb_dst), 64'(got.dst));
                chk({tag, "_wb_data"}, wb_data, got.data);
            end
        end
        @(negedge clk);
        chk({tag, "_wb_1cyc"}, 64'(wb_valid), 64'd0);
        chk({tag, "_ready"},   64'(req_ready), 64'd1);
    endtask

    initial begin
        bit any_wb;
        bit any_err;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_is32  = 1'b0;
        req_dst   = '0;
        req_value = '0;
        req_shift = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready",   64'(req_ready), 64'd1);
        chk("rst_stb",     64'(sh_stb), 64'd0);
        chk("rst_wb",      64'(wb_valid), 64'd0);
        chk("rst_err",     64'(err), 64'd0);
        chk("rst_value",   sh_value, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        rst_n = 1'b1;

        run_op("lsh64",  2'd0, 1'b0, 4'd3, 64'h1, 64'h44, 64'h10);
        run_op("arsh64", 2'd2, 1'b0, 4'd7, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("arsh32", 2'd2, 1'b1, 4'd1, 64'h1234_5678_8000_0000, 64'h21, 64'h0000_0000_C000_0000);
        run_op("rsh32",  2'd1, 1'b1, 4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 64'h0000_0000_0FFF_FFFF);
        run_op("rsh64",  2'd1, 1'b0, 4'd0, 64'hF000_0000_0000_0000, 64'd4, 64'h0F00_0000_0000_0000);
        run_op("lsh32",  2'd0, 1'b1, 4'd5, 64'hFFFF_FFFF_0000_0001, 64'd31, 64'h0000_0000_8000_0000);

        // Illegal opcode: error pulse, no issue, stays ready.
        drive_req(2'd3, 1'b0, 4'd2, 64'h55, 64'd1);
        @(negedge clk);
        chk("ill_err",   64'(err), 64'd1);
        chk("ill_stb",   64'(sh_stb), 64'd0);
        chk("ill_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("ill_err_1cyc", 64'(err), 64'd0);
        chk("ill_wb",       64'(wb_valid), 64'd0);

        for (int i = 0; i < 16; i++) begin
            logic [1:0]  op;
            logic        is32;
            logic [63:0] v;
            logic [63:0] s;
            op   = 2'($urandom_range(0, 2));
            is32 = 1'($urandom_range(0, 1));
            v    = {$urandom, $urandom};
            s    = {$urandom, $urandom};
            run_op("rnd", op, is32, 4'($urandom_range(0, 10)), v, s, ref_model(op, is32, v, s));
        end

        // Reset while in WAIT, then deliver the stale ack after release.
        ack_en = 1'b0;
        drive_req(2'd0, 1'b0, 4'd4, 64'h3, 64'd2);
        repeat (4) @(negedge clk);
        chk("mid_busy", 64'(req_ready), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        ack_en = 1'b1;
        any_wb = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (wb_valid) any_wb = 1'b1;
        end
        chk("stale_ack_wb",    64'(any_wb), 64'd0);
        chk("stale_ack_ready", 64'(req_ready), 64'd1);
        chk("stale_ack_stb",   64'(sh_stb), 64'd0);

        run_op("post_rst", 2'd1, 1'b0, 4'd9, 64'h100, 64'h48, 64'h1);

`ifdef SHIFT_TIMEOUT_EN
        // Withheld ack: expect a timeout error and a return to IDLE.
        ack_en  = 1'b0;
        drive_req(2'd1, 1'b0, 4'd6, 64'h80, 64'd1);
        any_err = 1'b0;
        any_wb  = 1'b0;
        for (int c = 0; c < 40 && !any_err; c++) begin
            @(negedge clk);
            if (err) any_err = 1'b1;
            if (wb_valid) any_wb = 1'b1;
        end
        chk("to_err",   64'(any_err), 64'd1);
        chk("to_wb",    64'(any_wb), 64'd0);
        chk("to_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("to_err_1cyc", 64'(err), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        repeat (3) @(negedge clk);
`else
        any_err = 1'b0;
`endif

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_issuer.md
Name: shift_issuer

Overview:
- Initiator side of the shifter stb/ack handshake.
- Accepts decoded eBPF shift instructions (LSH, RSH, ARSH; ALU64 and ALU32) from the execute stage.
- Masks the shift count and prepares the 32-bit operand, issues one request to the shifter, and waits for ack.
- Formats the result and presents it as a one-cycle register write-back to the register file.

Parameters:
- data_width, 64, operand/result width; must be 64 for eBPF semantics.
- reg_addr_width, 4, destination register index width (r0..r10).
- timeout_cycles, 16, max cycles in WAIT before abort (used only with SHIFT_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  upstream instruction valid.
- req_ready  output  1  high when IDLE; a transfer occurs when req_valid&req_ready.
- req_op  input  2  0=LSH, 1=RSH, 2=ARSH, 3=illegal.
- req_is32  input  1  1=ALU32 class, 0=ALU64.
- req_dst  input  reg_addr_width  destination register index.
- req_value  input  data_width  dst operand.
- req_shift  input  data_width  shift count (src register or immediate, already extended).
- sh_stb  output  1  request strobe to shifter.
- sh_arith  output  1  arithmetic right shift select.
- sh_left  output  1  left shift select.
- sh_value  output  data_width  operand to shifter.
- sh_shift  output  data_width  masked shift count.
- sh_out  input  data_width  shifter result.
- sh_ack  input  1  shifter completion, one-cycle pulse.
- wb_valid  output  1  one-cycle write-back strobe.
- wb_dst  output  reg_addr_width  write-back register index.
- wb_data  output  data_width  write-back value.
- err  output  1  one-cycle pulse on illegal op (or timeout when enabled).

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE. Outputs reset to: sh_stb=0, sh_arith=0, sh_left=0, sh_value=0, sh_shift=0, wb_valid=0, wb_dst=0, wb_data=0, err=0. req_ready=1 after reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On transfer with req_op=3: no issue, err=1 for one cycle, stay IDLE.
- IDLE, on legal transfer: latch dst, is32, op; go to ISSUE. Register the shifter inputs:
  - sh_left = (op==0); sh_arith = (op==2).
  - sh_shift = req_shift & 63 when ALU64, req_shift & 31 when ALU32; all upper bits zero.
  - sh_value for ALU64 = req_value.
  - sh_value for ALU32 ARSH = sign-extend of req_value[31:0].
  - sh_value for ALU32 LSH/RSH = zero-extend of req_value[31:0].
- ISSUE: sh_stb=1 for exactly one cycle; go to WAIT. The shifter restarts if stb is seen in its ack cycle, so the strobe is never held high.
- WAIT:
  - sh_value, sh_shift, sh_arith and sh_left stay stable until sh_ack; the shifter samples value[msb] after stb.
  - On sh_ack=1: capture sh_out. wb_data = sh_out for ALU64, {32'b0, sh_out[31:0]} for ALU32. Go to DONE.
- DONE: wb_valid=1 and wb_dst=latched dst for one cycle; wb_data holds until the next DONE. Then go to IDLE.
- Latency: legal transfer at edge T → sh_stb high in cycle T+1. With a shifter ack 2 cycles after stb, wb_valid is high in cycle T+4. Next request is accepted the cycle after DONE.
- sh_ack outside WAIT is ignored, including a stale ack after a reset mid-operation.
- Reset in any state returns to IDLE within that edge; the in-flight result is discarded and no wb_valid is produced.
- req_ready=0 in ISSUE, WAIT and DONE; req_valid is ignored there.

Optional Feature:
- SHIFT_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches timeout_cycles without sh_ack: err=1 for one cycle, no write-back, return to IDLE.
- SHIFT_TIMEOUT_EN undefined: no counter; WAIT persists until sh_ack; err is only raised for illegal op.

Test Plan:
- ALU64 LSH, value=0x1, shift=0x44 → sh_shift=4, sh_left=1, sh_stb one cycle; wb_data=0x10, wb_valid one cycle with wb_dst=req_dst.
- ALU64 ARSH, value=0x8000_0000_0000_0000, shift=63 → wb_data=0xFFFF_FFFF_FFFF_FFFF.
- ALU32 ARSH, value=0x1234_5678_8000_0000, shift=0x21 → sh_value=0xFFFF_FFFF_8000_0000, sh_shift=1; wb_data=0x0000_0000_C000_0000.
- ALU32 RSH, value=0xFFFF_FFFF_FFFF_FFFF, shift=4 → sh_value=0x0000_0000_FFFF_FFFF; wb_data=0x0000_0000_0FFF_FFFF.
- req_op=3 → err pulse, sh_stb stays 0, wb_valid stays 0, req_ready stays 1.
- Assert rst_n=0 during WAIT, then deliver sh_ack after release → no wb_valid, req_ready=1. With SHIFT_TIMEOUT_EN and ack withheld 16 cycles → err pulse, return to IDLE.
